// File: rtl/de2_115_sopc_ir_tx.sv
// de2_115_sopc_ir_tx: memory-mapped NEC consumer-IR transmitter.
// Software writes a 32-bit frame word. The block sends it LSB first as NEC
// pulse-distance code on a 50% duty carrier at ir_out.
//
// Bus handshake: a write is a single-cycle strobe on 'write' with
// address/writedata valid in that same cycle. Reads have no strobe:
// readdata is registered from 'address' and is valid one cycle after the
// address is presented.
//
// Optional feature: define IR_TX_REPEAT_EN to enable CONTROL bit1 (repeat).
// When it is set, a DATA write sends the short NEC repeat code instead of
// the frame. Without the macro only full frames are sent.
module de2_115_sopc_ir_tx #(
    parameter int CARRIER_DIV = 1316,
    parameter int UNIT_CYCLES = 28125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        ir_out
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int CW = $clog2(CARRIER_DIV);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_DIV - 1);
    localparam logic [CW-1:0] CAR_HALF  = CW'(CARRIER_DIV / 2);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5
    } state_t;

    state_t         state;
    logic [31:0]    data_reg;
    logic [31:0]    shift_reg;
    logic [UW-1:0]  unit_cnt;
    logic [3:0]     mult_cnt;
    logic [CW-1:0]  car_cnt;
    logic [4:0]     bit_idx;
    logic           done;
    logic           overrun;
    logic           irq_en;
    logic           rpt_bit;

`ifdef IR_TX_REPEAT_EN
    logic           rpt;
    logic           rpt_act;   // repeat mode captured at frame start
    assign rpt_bit = rpt;
`else
    assign rpt_bit = 1'b0;
`endif

    logic           busy;
    logic           data_wr;
    logic           status_wr;
    logic           ctrl_wr;
    logic           start;
    logic           unit_last;
    logic           seg_end;
    logic           is_mark;
    logic [4:0]     seg_len;
    logic [CW-1:0]  car_nxt;

    assign busy      = (state != IDLE);
    assign data_wr   = write && (address == 2'd0);
    assign status_wr = write && (address == 2'd1);
    assign ctrl_wr   = write && (address == 2'd2);
    assign start     = data_wr && !busy;
    assign unit_last = (unit_cnt == UNIT_LAST);
    assign seg_end   = busy && unit_last && ({1'b0, mult_cnt} == (seg_len - 5'd1));
    assign is_mark   = (state == LEAD_MARK) || (state == BIT_MARK) || (state == STOP_MARK);
    assign car_nxt   = (car_cnt == CAR_LAST) ? '0 : car_cnt + 1'b1;
    assign irq       = done && irq_en;

    // Length of the current state in NEC units.
    always_comb begin
        seg_len = 5'd1;
        case (state)
            LEAD_MARK:  seg_len = 5'd16;
`ifdef IR_TX_REPEAT_EN
            LEAD_SPACE: seg_len = rpt_act ? 5'd4 : 5'd8;
`else
            LEAD_SPACE: seg_len = 5'd8;
`endif
            BIT_SPACE:  seg_len = shift_reg[0] ? 5'd3 : 5'd1;
            default:    seg_len = 5'd1;
        endcase
    end

    // Software-visible data and control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
            irq_en   <= 1'b0;
`ifdef IR_TX_REPEAT_EN
            rpt      <= 1'b0;
`endif
        end else begin
            if (start) begin
                data_reg <= writedata;
            end
            if (ctrl_wr) begin
                irq_en <= writedata[0];
`ifdef IR_TX_REPEAT_EN
                rpt    <= writedata[1];
`endif
            end
        end
    end

    // Transmit FSM with unit/carrier counters, sticky status flags and the
    // registered carrier output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            unit_cnt  <= '0;
            mult_cnt  <= '0;
            car_cnt   <= '0;
            bit_idx   <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            ir_out    <= 1'b0;
`ifdef IR_TX_REPEAT_EN
            rpt_act   <= 1'b0;
`endif
        end else begin
            // W1C first so a completion on the same edge wins below.
            if (status_wr && writedata[1]) done    <= 1'b0;
            if (status_wr && writedata[2]) overrun <= 1'b0;
            // Includes the completion edge, since state is not yet IDLE.
            if (data_wr && busy)           overrun <= 1'b1;

            if (state == IDLE) begin
                ir_out <= 1'b0;
                if (start) begin
                    shift_reg <= writedata;
                    bit_idx   <= '0;
                    unit_cnt  <= '0;
                    mult_cnt  <= '0;
                    car_cnt   <= '0;
                    ir_out    <= 1'b1;
                    state     <= LEAD_MARK;
`ifdef IR_TX_REPEAT_EN
                    rpt_act   <= rpt;
`endif
                end
            end else if (seg_end) begin
                unit_cnt <= '0;
                mult_cnt <= '0;
                car_cnt  <= '0;
                case (state)
                    LEAD_MARK: begin
                        ir_out <= 1'b0;
                        state  <= LEAD_SPACE;
                    end
                    LEAD_SPACE: begin
                        ir_out <= 1'b1;
`ifdef IR_TX_REPEAT_EN
                        state  <= rpt_act ? STOP_MARK : BIT_MARK;
`else
                        state  <= BIT_MARK;
`endif
                    end
                    BIT_MARK: begin
                        ir_out <= 1'b0;
                        state  <= BIT_SPACE;
                    end
                    BIT_SPACE: begin
                        ir_out    <= 1'b1;
                        shift_reg <= {1'b0, shift_reg[31:1]};
                        bit_idx   <= bit_idx + 5'd1;
                        state     <= (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
                    end
                    default: begin
                        ir_out <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                endcase
            end else begin
                if (unit_last) begin
                    unit_cnt <= '0;
                    mult_cnt <= mult_cnt + 4'd1;
                end else begin
                    unit_cnt <= unit_cnt + 1'b1;
                end
                if (is_mark) begin
                    car_cnt <= car_nxt;
                    ir_out  <= (car_nxt < CAR_HALF);
                end else begin
                    ir_out  <= 1'b0;
                end
            end
        end
    end

    // Registered read mux, no read strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= data_reg;
                2'd1:    readdata <= {29'd0, overrun, done, busy};
                2'd2:    readdata <= {30'd0, rpt_bit, irq_en};
                default: readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_de2_115_sopc_ir_tx.sv
// Directed bench for de2_115_sopc_ir_tx with CARRIER_DIV=4, UNIT_CYCLES=8.
// Compile with IR_TX_REPEAT_EN to match an RTL build that has repeat enabled.
module tb_de2_115_sopc_ir_tx;

    localparam int CDIV      = 4;
    localparam int UNIT      = 8;
    localparam int FRAME_LEN = 968;   // 121 units for 0xEF10FF00
    localparam int REP_LEN   = 168;   // 21 units
    localparam int CYC_RESET = 300;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic        irq;
    logic        ir_out;
    logic [31:0] rdv;

    int tests_run = 0;
    int tests_failed = 0;
    logic exp_q[$];

    de2_115_sopc_ir_tx #(.CARRIER_DIV(CDIV), .UNIT_CYCLES(UNIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .ir_out    (ir_out)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    // Expected waveform model: marks are 1,1,0,0 carrier, spaces are 0.
    task automatic push_mark(input int units);
        for (int k = 0; k < units * UNIT; k++) exp_q.push_back((k % CDIV) < (CDIV / 2));
    endtask

    task automatic push_space(input int units);
        for (int k = 0; k < units * UNIT; k++) exp_q.push_back(1'b0);
    endtask

    task automatic build_frame(input logic [31:0] word, input bit rpt);
        exp_q.delete();
        push_mark(16);
        if (rpt) begin
            push_space(4);
        end else begin
            push_space(8);
            for (int b = 0; b < 32; b++) begin
                push_mark(1);
                push_space(word[b] ? 3 : 1);
            end
        end
        push_mark(1);
    endtask

    // Start a frame, compare ir_out each cycle, then check completion timing.
    task automatic run_frame(input string tag, input logic [31:0] word, input bit rpt,
                             input int len, input int ov_at, input logic [31:0] ov_data,
                             input logic exp_irq);
        int wave_err;
        int stat_err;
        bit skip;
        wave_err = 0;
        stat_err = 0;
        build_frame(word, rpt);
        wr(2'd0, word);
        address = 2'd1;
        skip = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i >= exp_q.size() || ir_out !== exp_q[i]) wave_err++;
            if (irq !== 1'b0) stat_err++;
            if (!skip && readdata[0] !== 1'b1) stat_err++;
            skip = 1'b0;
            if (i == ov_at) begin
                wr(2'd0, ov_data);
                address = 2'd1;
                skip = 1'b1;
            end else begin
                tick();
            end
        end
        check({tag, " wave"}, wave_err, 0);
        check({tag, " busy_during"}, stat_err, 0);
        check({tag, " busy_last"}, readdata[1:0], 2'b01);
        check({tag, " ir_out_end"}, ir_out, 1'b0);
        check({tag, " irq_end"}, irq, exp_irq);
        tick();
        check({tag, " status_end"}, readdata[2:0], (ov_at >= 0) ? 3'b110 : 3'b010);
    endtask

    task automatic clear_status(input string tag);
        logic [31:0] v;
        wr(2'd1, 32'h6);
        rd(2'd1, v);
        check({tag, " status_clear"}, v, 32'h0);
    endtask

    initial begin
        // 1: reset values and register reads
        repeat (3) @(posedge clk);
        #1;
        check("rst ir_out", ir_out, 1'b0);
        check("rst irq", irq, 1'b0);
        check("rst readdata", readdata, 32'h0);
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), rdv);
            check($sformatf("rst rd%0d", a), rdv, 32'h0);
        end

        // 2: basic frame
        run_frame("frame", 32'hEF10FF00, 1'b0, FRAME_LEN, -1, 32'h0, 1'b0);
        rd(2'd0, rdv);
        check("frame data_rd", rdv, 32'hEF10FF00);
        clear_status("frame");

        // 3: interrupt on completion, cleared by W1C
        wr(2'd2, 32'h1);
        rd(2'd2, rdv);
        check("irq ctrl_rd", rdv, 32'h1);
        run_frame("irq", 32'hEF10FF00, 1'b0, FRAME_LEN, -1, 32'h0, 1'b1);
        wr(2'd1, 32'h2);
        check("irq cleared", irq, 1'b0);
        rd(2'd1, rdv);
        check("irq status", rdv, 32'h0);
        wr(2'd2, 32'h0);

        // 4: write while busy is dropped and flagged
        run_frame("overrun", 32'hEF10FF00, 1'b0, FRAME_LEN, 9, 32'h0000_0000, 1'b0);
        rd(2'd0, rdv);
        check("overrun data_rd", rdv, 32'hEF10FF00);
        clear_status("overrun");

        // 5: repeat code (or plain frame when the feature is absent)
        wr(2'd2, 32'h2);
        rd(2'd2, rdv);
`ifdef IR_TX_REPEAT_EN
        check("repeat ctrl_rd", rdv, 32'h2);
        run_frame("repeat", 32'h1234ABCD, 1'b1, REP_LEN, -1, 32'h0, 1'b0);
`else
        check("repeat ctrl_rd", rdv, 32'h0);
        run_frame("norepeat", 32'hEF10FF00, 1'b0, FRAME_LEN, -1, 32'h0, 1'b0);
`endif
        wr(2'd2, 32'h0);
        clear_status("repeat");

        // 6: asynchronous reset in the middle of a frame
        wr(2'd2, 32'h1);
        wr(2'd0, 32'hEF10FF00);
        repeat (CYC_RESET - 1) tick();
        reset_n = 1'b0;
        #1;
        check("midrst ir_out", ir_out, 1'b0);
        check("midrst irq", irq, 1'b0);
        check("midrst readdata", readdata, 32'h0);
        tick();
        reset_n = 1'b1;
        rd(2'd1, rdv);
        check("midrst status", rdv, 32'h0);
        rd(2'd2, rdv);
        check("midrst ctrl", rdv, 32'h0);
        run_frame("postrst", 32'h00FF10EF, 1'b0, FRAME_LEN, -1, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
